// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute/commit sequencer owning the core's program counter.
// Optional PC_SEQ_TAKEN_CNT_EN adds a saturating count of taken redirects on taken_cnt.
module pc_sequencer #(
    parameter int              PC_W     = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_ack,
    input  logic            halt,
    input  logic            bez,
    input  logic            ja,
    input  logic [7:0]      x8,
    input  logic [PC_W-1:0] alu_target,
    output logic [PC_W-1:0] pc,
    output logic            fetch_req,
    output logic            exec_en,
    output logic            redirect,
    output logic            halted
`ifdef PC_SEQ_TAKEN_CNT_EN
    ,
    output logic [7:0]      taken_cnt
`endif
);
    typedef enum logic [1:0] {FETCH, EXEC, COMMIT, HALT} state_t;
    state_t          state, state_n;
    logic [PC_W-1:0] next_pc, next_pc_d;
    logic            take, take_d;
    always_comb begin
        state_n   = state;
        next_pc_d = next_pc;
        take_d    = take;
        case (state)
            // the ack only counts once the request is visible to memory
            FETCH:   state_n = (fetch_ack && fetch_req) ? EXEC : FETCH;
            EXEC: begin
                state_n   = halt ? HALT : COMMIT;
                take_d    = halt ? take : (ja || (bez && x8 != 8'd0));
                next_pc_d = halt ? next_pc : (take_d ? alu_target : pc + PC_W'(1));
            end
            COMMIT:  state_n = FETCH;
            default: state_n = HALT;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            next_pc   <= RESET_PC;
            take      <= 1'b0;
            fetch_req <= 1'b0;
            exec_en   <= 1'b0;
            redirect  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            next_pc   <= next_pc_d;
            take      <= take_d;
            pc        <= (state == COMMIT) ? next_pc : pc;
            fetch_req <= state_n == FETCH;
            exec_en   <= state_n == EXEC;
            redirect  <= state_n == COMMIT && take_d;
            halted    <= state_n == HALT;
        end
    end
`ifdef PC_SEQ_TAKEN_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            taken_cnt <= 8'd0;
        else if (state == COMMIT && take && taken_cnt != 8'hFF)
            taken_cnt <= taken_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven scoreboard bench for pc_sequencer.
// Define PC_SEQ_TAKEN_CNT_EN to also exercise taken_cnt saturation.
module tb_pc_sequencer;
    logic       clk = 0, reset = 1, fetch_ack = 0, halt = 0, bez = 0, ja = 0;
    logic [7:0] x8 = 0;
    logic [5:0] alu_target = 0, pc;
    logic       fetch_req, exec_en, redirect, halted;
`ifdef PC_SEQ_TAKEN_CNT_EN
    logic [7:0] taken_cnt;
`endif
    int tests = 0, fails = 0;
    logic [5:0] cur_pc;

    typedef struct {
        int         w;
        logic       ja, bez, hlt;
        logic [7:0] x8;
        logic [5:0] tgt, exp_pc;
        logic       exp_r;
    } vec_t;
    typedef struct {
        logic [5:0] pc;
        logic       r;
    } exp_t;
    vec_t v[15];
    exp_t q[$];

    pc_sequencer #(.PC_W(6), .RESET_PC(6'd0)) dut (
        .clk(clk), .reset(reset), .fetch_ack(fetch_ack), .halt(halt), .bez(bez), .ja(ja),
        .x8(x8), .alu_target(alu_target), .pc(pc), .fetch_req(fetch_req), .exec_en(exec_en),
        .redirect(redirect), .halted(halted)
`ifdef PC_SEQ_TAKEN_CNT_EN
        , .taken_cnt(taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run(input vec_t t, input int lat);
        int   n;
        exp_t e;
        fetch_ack = 0;
        for (int i = 0; i < t.w; i++) begin
            tick();
            chk("wait_no_exec", exec_en, 0);
            chk("wait_pc_hold", pc, cur_pc);
            chk("wait_fetch_req", fetch_req, 1);
        end
        fetch_ack = 1; ja = t.ja; bez = t.bez; x8 = t.x8; alu_target = t.tgt; halt = t.hlt;
        n = 0;
        do begin
            tick();
            n++;
        end while (!exec_en && n < 8);
        chk("exec_latency", n, lat);
        chk("exec_fetch_req_low", fetch_req, 0);
        q.push_back('{t.exp_pc, t.exp_r});
        tick();
        fetch_ack = 0; ja = 0; bez = 0; x8 = 0; alu_target = 0; halt = 0;
        e = q[0];
        chk("commit_no_exec", exec_en, 0);
        chk("commit_redirect", redirect, e.r);
        chk("commit_pc_not_yet", pc, cur_pc);
        tick();
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("redirect_one_cycle", redirect, 0);
        chk("fetch_req_back", fetch_req, 1);
        cur_pc = e.pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        vec_t t;
        //        w  ja bez hlt x8     tgt    exp_pc r
        v[0]  = '{0, 0, 0, 0, 8'h00, 6'h00, 6'h01, 0};
        v[1]  = '{0, 0, 0, 0, 8'h00, 6'h00, 6'h02, 0};
        v[2]  = '{0, 0, 0, 0, 8'h00, 6'h00, 6'h03, 0};
        v[3]  = '{0, 0, 1, 0, 8'h00, 6'h10, 6'h04, 0};
        v[4]  = '{5, 0, 0, 0, 8'h00, 6'h00, 6'h05, 0};
        v[5]  = '{0, 1, 0, 0, 8'h00, 6'h2A, 6'h2A, 1};
        v[6]  = '{0, 1, 0, 0, 8'h00, 6'h03, 6'h03, 1};
        v[7]  = '{0, 0, 1, 0, 8'h80, 6'h10, 6'h10, 1};
        v[8]  = '{0, 1, 1, 0, 8'h00, 6'h3F, 6'h3F, 1};
        v[9]  = '{0, 0, 0, 0, 8'h00, 6'h00, 6'h00, 0};
        v[10] = '{0, 0, 1, 0, 8'h01, 6'h3E, 6'h3E, 1};
        v[11] = '{0, 0, 0, 0, 8'h00, 6'h07, 6'h3F, 0};
        v[12] = '{0, 0, 1, 0, 8'h00, 6'h11, 6'h00, 0};
        v[13] = '{2, 1, 0, 0, 8'h00, 6'h19, 6'h19, 1};
        v[14] = '{0, 0, 0, 0, 8'h00, 6'h00, 6'h01, 0};

        tick();
        chk("reset_pc", pc, 0);
        chk("reset_fetch_req", fetch_req, 0);
        chk("reset_exec_en", exec_en, 0);
        chk("reset_redirect", redirect, 0);
        chk("reset_halted", halted, 0);
        reset = 0;
        cur_pc = 6'h00;
        for (int i = 0; i < 14; i++) run(v[i], i == 0 ? 2 : 1);

        // halt beats a simultaneous jump and freezes everything
        fetch_ack = 1; ja = 1; halt = 1; alu_target = 6'h22;
        n = 0;
        do begin
            tick();
            n++;
        end while (!exec_en && n < 8);
        chk("halt_exec_latency", n, 1);
        tick();
        ja = 0; halt = 0; alu_target = 0;
        chk("halted", halted, 1);
        chk("halt_pc", pc, cur_pc);
        chk("halt_fetch_req", fetch_req, 0);
        chk("halt_exec_en", exec_en, 0);
        chk("halt_redirect", redirect, 0);
        for (int i = 0; i < 4; i++) begin
            fetch_ack = i[0];
            tick();
            chk("halt_stay", halted, 1);
            chk("halt_no_exec", exec_en, 0);
            chk("halt_no_req", fetch_req, 0);
            chk("halt_pc_frozen", pc, cur_pc);
        end
        fetch_ack = 0;
        #2 reset = 1;
        #1;
        chk("halt_reset_pc", pc, 0);
        chk("halt_reset_halted", halted, 0);
        tick();
        reset = 0;
        cur_pc = 6'h00;

        // asynchronous reset in the middle of EXEC abandons the jump
        fetch_ack = 1; ja = 1; alu_target = 6'h15;
        n = 0;
        do begin
            tick();
            n++;
        end while (!exec_en && n < 8);
        chk("midexec_latency", n, 2);
        #2 reset = 1;
        #1;
        chk("midexec_exec_drop", exec_en, 0);
        chk("midexec_pc", pc, 0);
        chk("midexec_fetch_req", fetch_req, 0);
        chk("midexec_redirect", redirect, 0);
        fetch_ack = 0; ja = 0; alu_target = 0;
        tick();
        reset = 0;
        tick();
        chk("midexec_no_commit_redirect", redirect, 0);
        chk("midexec_no_commit_pc", pc, 0);
        chk("midexec_no_exec", exec_en, 0);
        run(v[14], 1);

`ifdef PC_SEQ_TAKEN_CNT_EN
        chk("cnt_after_reset", taken_cnt, 0);
        for (int i = 0; i < 260; i++) begin
            t = '{0, 1, 0, 0, 8'h00, 6'(i), 6'(i), 1};
            run(t, 1);
            if (i == 9) chk("cnt_10", taken_cnt, 10);
        end
        chk("cnt_saturated", taken_cnt, 255);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
